mvm_accum_ctrl: RTL and testbench
=================================

// Module: mvm_accum_ctrl
// PURPOSE
//  Sequencer for one MVM lane: memory read port -> dot-product pipe -> accum.
//  On start, walks an R x C tiled matrix-vector job one beat per cycle:
//  - issues vector/matrix read addresses;
//  - issues delay-matched ivalid/first/last to the accumulator;
//  - writes each returned row result to the output buffer, then pulses done.
// PARAMETERS
//  ROWW     8   width of num_rows and row counter
//  CHUNKW   8   width of num_chunks (beats per row) and chunk counter
//  VADDRW   8   vector memory address width (chunk index)
//  MADDRW   16  matrix memory address width (flat beat index, >= ROWW+CHUNKW)
//  OADDRW   8   output buffer address width
//  PIPE_LAT 2   cycles from mem_rd_en beat to matching accum_ivalid (>=1)
// PORTS
//  clk          in  1       clock
//  rst          in  1       synchronous reset, active-low (0 = reset)
//  start        in  1       job request, sampled only in IDLE
//  num_rows     in  ROWW    R, latched on accepted start
//  num_chunks   in  CHUNKW  C, latched on accepted start
//  busy         out 1       high whenever state != IDLE
//  done         out 1       1-cycle pulse at job completion
//  mem_rd_en    out 1       read strobe, one beat per cycle in RUN
//  vec_raddr    out VADDRW  chunk index c
//  mat_raddr    out MADDRW  r*C + c (running counter, no multiplier)
//  accum_ivalid out 1       to accum.ivalid
//  accum_first  out 1       to accum.first (c==0 of beat)
//  accum_last   out 1       to accum.last (c==C-1 of beat)
//  accum_ovalid in  1       from accum.ovalid
//  obuf_we      out 1       output buffer write enable
//  obuf_waddr   out OADDRW  row index of result being written
//  cycle_count  out 32      busy-cycle count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; counters and delay line cleared.
//  - FSM IDLE->RUN (start & R!=0 & C!=0), RUN->DRAIN (last beat issued),
//    DRAIN->DONE (R-th accum_ovalid), DONE->IDLE (unconditional).
//  - start with R==0 or C==0: IDLE->DONE; no reads issued.
//  - Cycle timing for start sampled at cycle 0:
//    - RUN spans cycles 1..R*C.
//    - mem_rd_en=1 each RUN cycle; c wraps C-1->0 and advances r.
//    - mat_raddr increments by 1 each beat.
//  - first/last/valid for each beat pass through a PIPE_LAT-deep shift register.
//    The accum_* outputs are registered and appear exactly PIPE_LAT cycles after the beat.
//  - C==1: first and last are both high on the same beat.
//  - Results: obuf_we = accum_ovalid while in RUN or DRAIN (combinational).
//    obuf_waddr = return count, starting at 0; the count increments after each write.
//  - accum_ovalid in IDLE/DONE, or after R returns: ignored, no write.
//  - done=1 only in the DONE cycle; busy falls the cycle after.
//  - start while busy: ignored. Config is stable for the whole job.
//  - rst low mid-job: immediate return to IDLE, delay line flushed, no done pulse.
//  - Counter widths: r in ROWW, c in CHUNKW, mat_raddr in MADDRW.
//    No overflow is possible for legal R*C.
// CONFIGURATION
//  MVM_CTRL_PERF_EN defined:
//    - cycle_count clears on accepted start.
//    - It increments every cycle busy=1 and holds after IDLE until the next start.
//    - Saturates at 2^32-1.
//  MVM_CTRL_PERF_EN undefined: cycle_count tied to 0; no counter logic.
// TESTING
//  T1 R=2,C=3,PIPE_LAT=2, start@0:
//    - mem_rd_en cycles 1-6; mat_raddr 0..5; vec_raddr 0,1,2,0,1,2.
//    - ivalid 3-8; first@3,6; last@5,8.
//    - ovalid@6,9 -> obuf_waddr 0,1.
//    - done@10, busy low@11.
//  T2 R=3,C=1: every accum beat has first=last=1; three obuf writes, addresses 0,1,2.
//  T3 R=0,C=5: no mem_rd_en or ivalid; done@1; busy low@2.
//  T4 start re-pulsed at cycles 2 and 4 of T1 job: no effect.
//     A second start@12 runs a clean job with obuf_waddr restarting at 0.
//  T5 rst=0 at cycle 4 of T1 for one cycle:
//     - outputs 0 next cycle; no done.
//     - Late accum_ovalid: no write.
//     - A new start then completes normally.
//  T6 PERF_EN, T1 job: cycle_count=10 after done; holds while IDLE; clears on next start.

Source files
------------

// File: rtl/mvm_accum_ctrl.sv
// mvm_accum_ctrl: sequencer for one MVM lane.
// It walks an R x C tiled matrix-vector job one beat per cycle, issuing vector and
// matrix read addresses. It sends delay-matched valid/first/last to the accumulator
// and writes each returned row result to the output buffer.
// Optional busy-cycle performance counter: define MVM_CTRL_PERF_EN.
module mvm_accum_ctrl #(
    parameter int ROWW     = 8,
    parameter int CHUNKW   = 8,
    parameter int VADDRW   = 8,
    parameter int MADDRW   = 16,
    parameter int OADDRW   = 8,
    parameter int PIPE_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ROWW-1:0]   num_rows,
    input  logic [CHUNKW-1:0] num_chunks,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [VADDRW-1:0] vec_raddr,
    output logic [MADDRW-1:0] mat_raddr,
    output logic              accum_ivalid,
    output logic              accum_first,
    output logic              accum_last,
    input  logic              accum_ovalid,
    output logic              obuf_we,
    output logic [OADDRW-1:0] obuf_waddr,
    output logic [31:0]       cycle_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    // Latched job shape and walk counters
    logic [ROWW-1:0]   r_num_rows;
    logic [CHUNKW-1:0] r_num_chunks;
    logic [ROWW-1:0]   r_row;
    logic [CHUNKW-1:0] r_chunk;
    logic [MADDRW-1:0] r_maddr;
    logic [ROWW-1:0]   r_ret_cnt;

    // Beat-side control delay line; the last stage drives the accumulator
    logic [PIPE_LAT-1:0] r_dl_vld;
    logic [PIPE_LAT-1:0] r_dl_first;
    logic [PIPE_LAT-1:0] r_dl_last;

    logic w_busy;
    logic w_done;
    logic w_mem_rd_en;
    logic w_active;
    logic w_accept;
    logic w_empty_job;
    logic w_last_beat;
    logic w_row_end;
    logic w_first_in;
    logic w_last_in;
    logic w_obuf_we;
    logic w_all_returned;
    logic w_final_return;

    assign w_accept    = (r_state == S_IDLE) && start;
    assign w_empty_job = (num_rows == '0) || (num_chunks == '0);
    assign w_row_end   = (r_chunk == r_num_chunks - 1'b1);
    assign w_last_beat = w_row_end && (r_row == r_num_rows - 1'b1);

    // A beat's first/last flags follow its chunk position within the row
    assign w_first_in = w_mem_rd_en && (r_chunk == '0);
    assign w_last_in  = w_mem_rd_en && w_row_end;

    // Results are accepted only while a job is live and rows remain outstanding
    assign w_all_returned = (r_ret_cnt == r_num_rows);
    assign w_obuf_we      = accum_ovalid && w_active && !w_all_returned;
    assign w_final_return = w_obuf_we && (r_ret_cnt == r_num_rows - 1'b1);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_empty_job ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last_beat) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_all_returned || w_final_return) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State-decoded outputs
    always_comb begin
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_mem_rd_en = 1'b0;
        w_active    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
            end
            S_RUN: begin
                w_busy      = 1'b1;
                w_mem_rd_en = 1'b1;
                w_active    = 1'b1;
            end
            S_DRAIN: begin
                w_busy   = 1'b1;
                w_active = 1'b1;
            end
            S_DONE: begin
                w_busy = 1'b1;
                w_done = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // Job latch, row/chunk walk, running matrix address and return count
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_num_rows   <= '0;
            r_num_chunks <= '0;
            r_row        <= '0;
            r_chunk      <= '0;
            r_maddr      <= '0;
            r_ret_cnt    <= '0;
        end else begin
            if (w_accept) begin
                r_num_rows   <= num_rows;
                r_num_chunks <= num_chunks;
                r_row        <= '0;
                r_chunk      <= '0;
                r_maddr      <= '0;
                r_ret_cnt    <= '0;
            end else if (w_mem_rd_en) begin
                r_maddr <= r_maddr + 1'b1;
                if (w_row_end) begin
                    r_chunk <= '0;
                    r_row   <= r_row + 1'b1;
                end else begin
                    r_chunk <= r_chunk + 1'b1;
                end
            end
            if (w_obuf_we) begin
                r_ret_cnt <= r_ret_cnt + 1'b1;
            end
        end
    end

    // Delay line aligning beat flags with the dot-product pipe latency
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dl_vld   <= '0;
            r_dl_first <= '0;
            r_dl_last  <= '0;
        end else begin
            r_dl_vld[0]   <= w_mem_rd_en;
            r_dl_first[0] <= w_first_in;
            r_dl_last[0]  <= w_last_in;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_dl_vld[i]   <= r_dl_vld[i-1];
                r_dl_first[i] <= r_dl_first[i-1];
                r_dl_last[i]  <= r_dl_last[i-1];
            end
        end
    end

`ifdef MVM_CTRL_PERF_EN
    logic [31:0] r_cycle_count;

    // Busy-cycle counter: clears on an accepted start, saturates, holds while idle
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cycle_count <= '0;
        end else if (w_accept) begin
            r_cycle_count <= '0;
        end else if (w_busy && (r_cycle_count != 32'hFFFF_FFFF)) begin
            r_cycle_count <= r_cycle_count + 32'd1;
        end
    end

    assign cycle_count = r_cycle_count;
`else
    assign cycle_count = 32'd0;
`endif

    assign busy         = w_busy;
    assign done         = w_done;
    assign mem_rd_en    = w_mem_rd_en;
    assign vec_raddr    = VADDRW'(r_chunk);
    assign mat_raddr    = r_maddr;
    assign accum_ivalid = r_dl_vld[PIPE_LAT-1];
    assign accum_first  = r_dl_first[PIPE_LAT-1];
    assign accum_last   = r_dl_last[PIPE_LAT-1];
    assign obuf_we      = w_obuf_we;
    assign obuf_waddr   = OADDRW'(r_ret_cnt);

endmodule

// File: tb/tb_mvm_accum_ctrl.sv
// Testbench for mvm_accum_ctrl: directed jobs plus randomized job shapes and
// accumulator return latencies, checked against an arithmetic per-cycle model.
module tb_mvm_accum_ctrl;

    localparam int P = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  num_rows;
    logic [7:0]  num_chunks;
    logic        busy;
    logic        done;
    logic        mem_rd_en;
    logic [7:0]  vec_raddr;
    logic [15:0] mat_raddr;
    logic        accum_ivalid;
    logic        accum_first;
    logic        accum_last;
    logic        accum_ovalid;
    logic        obuf_we;
    logic [7:0]  obuf_waddr;
    logic [31:0] cycle_count;

    int passed = 0;
    int total  = 0;
    int cc_hold = 0;

    always #5 clk = ~clk;

    mvm_accum_ctrl #(
        .ROWW(8), .CHUNKW(8), .VADDRW(8), .MADDRW(16), .OADDRW(8), .PIPE_LAT(P)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .num_rows(num_rows), .num_chunks(num_chunks),
        .busy(busy), .done(done), .mem_rd_en(mem_rd_en),
        .vec_raddr(vec_raddr), .mat_raddr(mat_raddr),
        .accum_ivalid(accum_ivalid), .accum_first(accum_first), .accum_last(accum_last),
        .accum_ovalid(accum_ovalid), .obuf_we(obuf_we), .obuf_waddr(obuf_waddr),
        .cycle_count(cycle_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One job: start at k=0, accumulator returns each row L cycles after its last beat.
    // Called and returns just after a rising edge with the DUT idle.
    task automatic run_job(input int R, input int C, input int L,
                           input bit repulse, input bit stray, input string nm);
        int nbeat, tdone, x, pb, row;
        int e_busy, e_done, e_rd, e_iv, e_first, e_last, e_we, e_cc;
        nbeat = R * C;
        tdone = (nbeat == 0) ? 1 : nbeat + P + L + 1;
        for (int k = 0; k <= tdone + 1; k++) begin
            num_rows   = 8'(R);
            num_chunks = 8'(C);
            start      = (k == 0) || (repulse && (k == 2 || k == 4));
            e_we = 0;
            row  = 0;
            x = k - P - L;
            if (nbeat != 0 && x > 0 && (x % C) == 0 && (x / C) <= R) begin
                e_we = 1;
                row  = x / C - 1;
            end
            accum_ovalid = (e_we == 1) || (stray && k >= tdone);

            e_busy = (k >= 1 && k <= tdone) ? 1 : 0;
            e_done = (k == tdone) ? 1 : 0;
            e_rd   = (k >= 1 && k <= nbeat) ? 1 : 0;
            pb = k - P - 1;
            e_iv = 0; e_first = 0; e_last = 0;
            if (pb >= 0 && pb < nbeat) begin
                e_iv    = 1;
                e_first = ((pb % C) == 0) ? 1 : 0;
                e_last  = ((pb % C) == C - 1) ? 1 : 0;
            end
`ifdef MVM_CTRL_PERF_EN
            e_cc = (k == 0) ? cc_hold : ((k - 1 < tdone) ? k - 1 : tdone);
`else
            e_cc = 0;
`endif
            @(negedge clk);
            chk($sformatf("%s k=%0d busy", nm, k), 32'(busy), e_busy);
            chk($sformatf("%s k=%0d done", nm, k), 32'(done), e_done);
            chk($sformatf("%s k=%0d mem_rd_en", nm, k), 32'(mem_rd_en), e_rd);
            if (e_rd == 1) begin
                chk($sformatf("%s k=%0d vec_raddr", nm, k), 32'(vec_raddr), (k - 1) % C);
                chk($sformatf("%s k=%0d mat_raddr", nm, k), 32'(mat_raddr), k - 1);
            end
            chk($sformatf("%s k=%0d ivalid", nm, k), 32'(accum_ivalid), e_iv);
            chk($sformatf("%s k=%0d first", nm, k), 32'(accum_first), e_first);
            chk($sformatf("%s k=%0d last", nm, k), 32'(accum_last), e_last);
            chk($sformatf("%s k=%0d obuf_we", nm, k), 32'(obuf_we), e_we);
            if (e_we == 1)
                chk($sformatf("%s k=%0d obuf_waddr", nm, k), 32'(obuf_waddr), row);
            chk($sformatf("%s k=%0d cycle_count", nm, k), cycle_count, e_cc);
            @(posedge clk);
            #1;
        end
        start        = 1'b0;
        accum_ovalid = 1'b0;
`ifdef MVM_CTRL_PERF_EN
        cc_hold = tdone;
`endif
    endtask

    initial begin
        int rr, cc, ll;
        bit rp, st;

        rst = 1'b0; start = 1'b0; accum_ovalid = 1'b0;
        num_rows = 8'd0; num_chunks = 8'd0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset mem_rd_en", 32'(mem_rd_en), 0);
        chk("reset ivalid", 32'(accum_ivalid), 0);
        chk("reset obuf_we", 32'(obuf_we), 0);
        chk("reset mat_raddr", 32'(mat_raddr), 0);
        chk("reset cycle_count", cycle_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Directed jobs
        run_job(2, 3, 1, 1'b0, 1'b1, "T1");
        run_job(3, 1, 1, 1'b0, 1'b0, "T2");
        run_job(0, 5, 1, 1'b0, 1'b0, "T3");
        run_job(4, 0, 1, 1'b0, 1'b0, "T3b");
        run_job(2, 3, 1, 1'b1, 1'b0, "T4");
        run_job(2, 3, 1, 1'b0, 1'b0, "T4b");

        // Mid-job reset
        num_rows = 8'd2; num_chunks = 8'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("T5 k=%0d busy", k), 32'(busy), 1);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(negedge clk);
        chk("T5 k=4 busy", 32'(busy), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 5; k <= 12; k++) begin
            accum_ovalid = (k == 6 || k == 9);
            @(negedge clk);
            chk($sformatf("T5 k=%0d busy", k), 32'(busy), 0);
            chk($sformatf("T5 k=%0d done", k), 32'(done), 0);
            chk($sformatf("T5 k=%0d mem_rd_en", k), 32'(mem_rd_en), 0);
            chk($sformatf("T5 k=%0d ivalid", k), 32'(accum_ivalid), 0);
            chk($sformatf("T5 k=%0d first", k), 32'(accum_first), 0);
            chk($sformatf("T5 k=%0d last", k), 32'(accum_last), 0);
            chk($sformatf("T5 k=%0d obuf_we", k), 32'(obuf_we), 0);
            chk($sformatf("T5 k=%0d mat_raddr", k), 32'(mat_raddr), 0);
            chk($sformatf("T5 k=%0d vec_raddr", k), 32'(vec_raddr), 0);
            chk($sformatf("T5 k=%0d cycle_count", k), cycle_count, 0);
            @(posedge clk);
            #1;
        end
        accum_ovalid = 1'b0;
        cc_hold = 0;
        run_job(2, 3, 1, 1'b0, 1'b0, "T5b");

        // Randomized jobs
        for (int j = 0; j < 20; j++) begin
            rr = int'($urandom_range(0, 6));
            cc = int'($urandom_range(0, 5));
            ll = int'($urandom_range(1, 3));
            rp = (rr * cc != 0) && ($urandom_range(0, 1) == 1);
            st = ($urandom_range(0, 1) == 1);
            run_job(rr, cc, ll, rp, st, $sformatf("R%0d", j));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
